// File: rtl/fnd_time_ctrl.sv
// 4-digit multiplexed 7-segment driver for the watch time fields, snapshotting once per scan frame.
// Optional macro FND_BLANK_LEAD_EN blanks digit 3 when its value is zero.
module fnd_time_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       sw_mode,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int DIV   = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] scan_cnt;
  logic             scan_tick;
  logic [1:0]       digit_sel;

  logic [6:0] snap_msec;
  logic [5:0] snap_sec;
  logic [5:0] snap_min;
  logic [4:0] snap_hour;
  logic       snap_mode;

  logic [6:0] lo_val;
  logic [6:0] hi_val;
  logic [3:0] digit_val;
  logic       dp_n;
  logic       lead_blank;
  logic [7:0] data_next;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'h40;
      4'd1:    seg_encode = 7'h79;
      4'd2:    seg_encode = 7'h24;
      4'd3:    seg_encode = 7'h30;
      4'd4:    seg_encode = 7'h19;
      4'd5:    seg_encode = 7'h12;
      4'd6:    seg_encode = 7'h02;
      4'd7:    seg_encode = 7'h78;
      4'd8:    seg_encode = 7'h00;
      4'd9:    seg_encode = 7'h10;
      default: seg_encode = 7'h7F;
    endcase
  endfunction

  assign scan_tick = (scan_cnt == CNT_W'(DIV - 1));

  // Decode stage: select the decimal digit for the active position from the frame snapshot
  always_comb begin
    lo_val    = snap_mode ? {1'b0, snap_min}  : snap_msec;
    hi_val    = snap_mode ? {2'b00, snap_hour} : {1'b0, snap_sec};
    digit_val = 4'd0;
    case (digit_sel)
      2'd0:    digit_val = 4'(lo_val % 7'd10);
      2'd1:    digit_val = 4'(lo_val / 7'd10);
      2'd2:    digit_val = 4'(hi_val % 7'd10);
      default: digit_val = 4'(hi_val / 7'd10);
    endcase
    // Separator dot blinks off the msec snapshot regardless of mode
    dp_n = !((digit_sel == 2'd2) && (snap_msec < 7'd50));
`ifdef FND_BLANK_LEAD_EN
    lead_blank = (digit_sel == 2'd3) && (digit_val == 4'd0);
`else
    lead_blank = 1'b0;
`endif
    data_next = lead_blank ? 8'hFF : {dp_n, seg_encode(digit_val)};
  end

  // Register stage: scan counters, frame snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd0;
      snap_msec <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
      snap_mode <= 1'b0;
      fnd_com   <= 4'b1111;
      fnd_data  <= 8'hFF;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) begin
        digit_sel <= digit_sel + 2'd1;
      end
      // Capture on the same edge digit_sel wraps to 0 so a whole frame shows one time value
      if (scan_tick && (digit_sel == 2'd3)) begin
        snap_msec <= msec;
        snap_sec  <= sec;
        snap_min  <= min;
        snap_hour <= hour;
        snap_mode <= sw_mode;
      end
      fnd_com  <= ~(4'b0001 << digit_sel);
      fnd_data <= data_next;
    end
  end

endmodule

// File: tb/tb_fnd_time_ctrl.sv
// Directed bench for fnd_time_ctrl (DIV = 10): expected digit outputs queued as inputs are driven, checked at sample points.
module tb_fnd_time_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       sw_mode;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

`ifdef FND_BLANK_LEAD_EN
  localparam logic [7:0] LEAD0 = 8'hFF;
`else
  localparam logic [7:0] LEAD0 = 8'hC0;
`endif

  typedef struct {
    string      tag;
    logic [3:0] com;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cur    = 0;

  fnd_time_ctrl #(.CLK_FREQ(100), .SCAN_HZ(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .sw_mode  (sw_mode),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  always #5 clk = ~clk;

  task automatic push_raw(input string tag, input logic [3:0] com, input logic [7:0] data);
    exp_t e;
    e.tag  = tag;
    e.com  = com;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic push(input string tag, input int d, input logic [7:0] data);
    logic [3:0] com;
    com    = 4'b1111;
    com[d] = 1'b0;
    push_raw(tag, com, data);
  endtask

  task automatic check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: no expected entry for com=%b data=%h", fnd_com, fnd_data);
    end else begin
      e = sb.pop_front();
      assert (fnd_com === e.com && fnd_data === e.data) passed++;
      else $error("FAIL %s: got com=%b data=%h, expected com=%b data=%h",
                  e.tag, fnd_com, fnd_data, e.com, e.data);
    end
  endtask

  // Advance to the falling edge following rising edge number n after reset release
  task automatic goto(input int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic step(input int n);
    goto(n);
    check();
  endtask

  initial begin
    sec = 6'd37; msec = 7'd25; min = 6'd0; hour = 5'd0; sw_mode = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push_raw("reset_state", 4'b1111, 8'hFF);
    check();

    // Frame 1 shows the cleared snapshot; frame 2 the sec=37 msec=25 capture
    push("f1_d0", 0, 8'hC0);
    push("f1_d1", 1, 8'hC0);
    push("f1_d2", 2, 8'h40);
    push("f1_d3", 3, LEAD0);
    push("f2_d0", 0, 8'h92);
    push("f2_d1", 1, 8'hA4);
    push("f2_d2", 2, 8'h78);
    push("f2_d3", 3, 8'hB0);
    rst = 1'b0;
    cur = -1;
    step(0);
    step(10);
    step(20);
    step(30);
    step(40);

    goto(45);
    sw_mode = 1'b1; hour = 5'd9; min = 6'd5; msec = 7'd80;
    push("m1_d0", 0, 8'h92);
    push("m1_d1", 1, 8'hC0);
    push("m1_d2", 2, 8'h90);
    push("m1_d3", 3, LEAD0);
    step(50);
    step(60);
    step(70);
    step(80);

    goto(85);
    sw_mode = 1'b0; sec = 6'd12; msec = 7'd60;
    push("s12_d0", 0, 8'hC0);
    push("s12_d1", 1, 8'h82);
    push("s12_d2", 2, 8'hA4);
    push("s12_d3", 3, 8'hF9);
    step(90);
    step(100);
    step(110);
    step(120);
    step(130);

    goto(135);
    sec = 6'd45;
    push("s45_d0", 0, 8'hC0);
    push("s45_d1", 1, 8'h82);
    push("s45_d2", 2, 8'h92);
    push("s45_d3", 3, 8'h99);
    step(140);
    step(150);
    step(160);

    goto(165);
    msec = 7'd120;
    push("oor_d0", 0, 8'hC0);
    push("oor_d1", 1, 8'hFF);
    step(170);
    step(180);
    step(190);
    step(200);
    step(210);

    goto(225);
    rst = 1'b1;
    push_raw("midrst", 4'b1111, 8'hFF);
    push("post_d0", 0, 8'hC0);
    push("post_d1", 1, 8'hC0);
    push("post_d2", 2, 8'h40);
    step(226);
    rst = 1'b0;
    step(227);
    step(237);
    step(247);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fnd_time_ctrl.md
Name: fnd_time_ctrl

Overview:
- Reader and display end of the watch datapath.
- Takes the binary time fields from the watch datapath (msec, sec, min, hour) and drives a 4-digit multiplexed 7-segment display (FND).
- Scans the digits, converts binary to decimal, and snapshots time once per scan frame so the display never tears.
- Mode switch selects SS.CC or HH.MM; the separator dot blinks at the half-second.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. DIV = CLK_FREQ/SCAN_HZ clocks per digit; DIV >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- msec  input  7  hundredths of a second, 0..99.
- sec  input  6  seconds, 0..59.
- min  input  6  minutes, 0..59.
- hour  input  5  hours, 0..23.
- sw_mode  input  1  0 = sec.msec, 1 = hour.min.
- fnd_com  output  4  digit enables, active-low; bit0 = rightmost digit.
- fnd_data  output  8  segments, active-low; bit7 = dp, bits6..0 = g..a.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high, sampled on posedge clk only.
- Reset values:
  - scan_cnt = 0, digit_sel = 0.
  - Snapshot registers (time fields, mode) = 0.
  - fnd_com = 4'b1111 (all digits off), fnd_data = 8'hFF.
- Scan divider:
  - scan_cnt counts 0..DIV-1 and wraps.
  - scan_tick is asserted combinationally when scan_cnt == DIV-1.
- Digit select:
  - 2-bit digit_sel increments on scan_tick and wraps 3 -> 0.
  - Each digit is active for exactly DIV cycles.
- Snapshot:
  - On the edge where scan_tick && digit_sel == 3, capture msec, sec, min, hour and sw_mode into snapshot registers.
  - That is the same edge on which digit_sel becomes 0.
  - Input changes between snapshots are invisible. A mode change takes effect at the next frame start.
- Digit values, from the snapshot:
  - Mode 0: d3 = sec/10, d2 = sec%10, d1 = msec/10, d0 = msec%10.
  - Mode 1: d3 = hour/10, d2 = hour%10, d1 = min/10, d0 = min%10.
- Out-of-range inputs (e.g. msec 100..127) give a tens value > 9. Any digit value > 9 displays blank segments (bits6..0 = 7'h7F).
- Segment codes (bits6..0): 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
- DP:
  - Lit (bit7 = 0) only on digit 2, and only when snapshot msec < 50, in both modes.
  - Otherwise bit7 = 1.
- Output timing:
  - fnd_com and fnd_data are registered.
  - They reflect the digit_sel and snapshot values present in the previous cycle (1-cycle latency).
  - fnd_com = ~(4'b0001 << digit_sel).
  - Exactly one fnd_com bit is low at all times after the first post-reset cycle.
- Reset mid-frame: all counters and snapshot clear on the same edge. Scanning restarts at digit 0 showing 00.00.
- Simultaneous events: scan_tick at digit_sel == 3 performs the wrap and the snapshot in one edge; neither is dropped.

Optional Feature:
- Macro: FND_BLANK_LEAD_EN.
- Defined: when digit 3's value == 0, digit 3 shows blank segments (8'hFF) while fnd_com still scans it. DP behaviour is unchanged.
- Undefined: leading zero is displayed as 0 (fnd_data = 8'hC0).

Test Plan:
- Reset, then release (CLK_FREQ=100, SCAN_HZ=10, DIV=10):
  - Required: 1 cycle after release fnd_com = 4'b1110, fnd_data = 8'hC0.
  - fnd_com steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, every 10 cycles.
- Mode 0 with sec=37, msec=25, held for a full frame:
  - Next frame digits 3..0 = 3, 7, 2, 5.
  - fnd_data = B0, 78 (dp lit), A4, 92.
- Mode 1 with hour=9, min=5, msec=80:
  - Digits = 0, 9, 0, 5, with fnd_data digit 2 = 8'h90 (dp off).
  - With FND_BLANK_LEAD_EN defined, digit 3 = 8'hFF; without it, digit 3 = 8'hC0.
- Change sec from 12 to 45 while digit 1 is active:
  - Remaining digits of the current frame still show 12.
  - The new value appears only after the digit_sel 3 -> 0 wrap.
- Out-of-range msec=120, mode 0:
  - Digit 1 shows blank bits6..0 = 7F (fnd_data = 8'hFF); digit 0 shows 0.
- Assert rst for 1 cycle while digit 2 is active:
  - Next cycle fnd_com = 4'b1111, fnd_data = 8'hFF.
  - Scanning then resumes at digit 0 with snapshot 0.
